iic_write_engine: RTL and testbench

I2C bit-level write engine for the audio/video codec configuration path. It sits directly downstream of the register-table sequencer. It accepts one 24-bit frame (device address byte plus two register bytes) under a Go/End handshake, serialises it onto the open-drain SCL/SDA pins, and reports the combined slave acknowledge. Everything runs from the system clock with a quarter-bit clock enable; no derived clocks.

---
 rtl/iic_pkg.sv | 28 ++
 rtl/iic_quarter_tick.sv | 27 ++
 rtl/iic_write_engine.sv | 154 +++++++++++++++
 tb/tb_iic_write_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iic_pkg.sv
// Shared types and constants for the I2C codec-configuration write engine.
package iic_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_BITS,
      ST_STOP,
      ST_DONE
   } iic_state_t;

   localparam int SLOT_COUNT     = 27;
   localparam int ACK_SLOT_COUNT = 3;
   // Packed list of the ACK slot indices: 8, 17, 26 (5 bits each, index 0 in the LSBs).
   localparam logic [14:0] ACK_SLOTS = {5'd26, 5'd17, 5'd8};

   localparam int START_QUARTERS = 2;
   localparam int SLOT_QUARTERS  = 4;
   localparam int STOP_QUARTERS  = 3;

   localparam logic [7:0] ADDR_AUDIO = 8'h34;
   localparam logic [7:0] ADDR_VIDEO = 8'h40;

   function automatic int calc_qdiv(input int clk_freq, input int i2c_freq);
      return clk_freq / (4 * i2c_freq);
   endfunction

endpackage

// File: rtl/iic_quarter_tick.sv
// Quarter-bit clock-enable divider: one-cycle Tick every DIV cycles, held at 0 by Clear.
module iic_quarter_tick #(
   parameter int DIV = 625
) (
   input  logic Clk_In,
   input  logic Reset,
   input  logic Clear,
   output logic Tick
);

   localparam int W = $clog2(DIV);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge Clk_In) begin
      if (Reset || Clear) begin
         cnt_reg <= '0;
      end else if (cnt_reg == W'(DIV - 1)) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign Tick = (cnt_reg == W'(DIV - 1));

endmodule

// File: rtl/iic_write_engine.sv
// I2C bit-level write engine: serialises one 24-bit frame (address + register word)
// onto SCL/SDA under a Go/End handshake and reports the combined slave acknowledge.
module iic_write_engine
   import iic_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int I2C_FREQ = 20000
) (
   input  logic        Clk_In,
   input  logic        Reset,
   input  logic [23:0] IIC_Data,
   input  logic        Go,
   output logic        End,
   output logic        Ack,
   output logic        IIC_Sclk,
   inout  wire         IIC_Sda
);

   localparam int QDIV = calc_qdiv(CLK_FREQ, I2C_FREQ);

   generate
      if (QDIV < 2) begin : g_qdiv_check
         $fatal(1, "iic_write_engine: quarter divider must be at least 2");
      end
   endgenerate

   iic_state_t  state_reg;
   logic [4:0]  slot_reg;
   logic [1:0]  q_cnt_reg;
   logic [23:0] shift_reg;
   logic        nack_reg;
   logic        sclk_reg;
   logic        sda_low_reg;
   logic        end_reg;
   logic        ack_reg;

   logic                      q_tick;
   logic                      ack_slot;
   logic [ACK_SLOT_COUNT-1:0] ack_hit;

   for (genvar gi = 0; gi < ACK_SLOT_COUNT; gi++) begin : g_ack_slot
      assign ack_hit[gi] = (slot_reg == ACK_SLOTS[gi*5 +: 5]);
   end
   assign ack_slot = |ack_hit;

   iic_quarter_tick #(
      .DIV(QDIV)
   ) u_quarter_tick (
      .Clk_In (Clk_In),
      .Reset  (Reset),
      .Clear  (state_reg == ST_IDLE),
      .Tick   (q_tick)
   );

   always_ff @(posedge Clk_In) begin
      if (Reset) begin
         state_reg   <= ST_IDLE;
         slot_reg    <= '0;
         q_cnt_reg   <= '0;
         shift_reg   <= '0;
         nack_reg    <= 1'b0;
         sclk_reg    <= 1'b1;
         sda_low_reg <= 1'b0;
         end_reg     <= 1'b0;
         ack_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               sclk_reg    <= 1'b1;
               sda_low_reg <= 1'b0;
               end_reg     <= 1'b0;
               if (Go) begin
                  shift_reg <= IIC_Data;
                  nack_reg  <= 1'b0;
                  ack_reg   <= 1'b0;
                  slot_reg  <= '0;
                  q_cnt_reg <= '0;
                  state_reg <= ST_START;
               end
            end
            ST_START: begin
               if (q_tick) begin
                  if (q_cnt_reg == 2'(START_QUARTERS - 1)) begin
                     sclk_reg  <= 1'b0;
                     q_cnt_reg <= '0;
                     slot_reg  <= '0;
                     state_reg <= ST_BITS;
                  end else begin
                     sda_low_reg <= 1'b1;
                     q_cnt_reg   <= q_cnt_reg + 1'b1;
                  end
               end
            end
            ST_BITS: begin
               if (q_tick) begin
                  q_cnt_reg <= q_cnt_reg + 1'b1;
                  case (q_cnt_reg)
                     2'd0: begin
                        sclk_reg    <= 1'b0;
                        sda_low_reg <= ack_slot ? 1'b0 : ~shift_reg[23];
                     end
                     2'd1: sclk_reg <= 1'b1;
                     // Sample mid SCL-high; a released (pulled-up) SDA in an ACK slot is a NACK.
                     2'd2: if (ack_slot && IIC_Sda) nack_reg <= 1'b1;
                     default: begin
                        sclk_reg <= 1'b0;
                        if (!ack_slot) shift_reg <= {shift_reg[22:0], 1'b0};
                        if (slot_reg == 5'(SLOT_COUNT - 1)) begin
                           state_reg <= ST_STOP;
                        end else begin
                           slot_reg <= slot_reg + 1'b1;
                        end
                     end
                  endcase
               end
            end
            ST_STOP: begin
               if (q_tick) begin
                  if (q_cnt_reg == 2'd0) begin
                     sclk_reg    <= 1'b0;
                     sda_low_reg <= 1'b1;
                     q_cnt_reg   <= q_cnt_reg + 1'b1;
                  end else if (q_cnt_reg == 2'(STOP_QUARTERS - 1)) begin
                     sda_low_reg <= 1'b0;
                     q_cnt_reg   <= '0;
                     state_reg   <= ST_DONE;
                  end else begin
                     sclk_reg  <= 1'b1;
                     q_cnt_reg <= q_cnt_reg + 1'b1;
                  end
               end
            end
            ST_DONE: begin
               // First DONE cycle raises End; a Go already low makes it a single-cycle pulse.
               if (!end_reg) begin
                  end_reg <= 1'b1;
                  ack_reg <= nack_reg;
                  if (!Go) state_reg <= ST_IDLE;
               end else if (!Go) begin
                  end_reg   <= 1'b0;
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign End      = end_reg;
   assign Ack      = ack_reg;
   assign IIC_Sclk = sclk_reg;
   assign IIC_Sda  = sda_low_reg ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_write_engine.sv
// Directed bench for iic_write_engine with an open-drain slave model and pull-up on SDA.
`timescale 1ns/1ps
module tb_iic_write_engine;

   logic        Clk_In   = 1'b0;
   logic        Reset    = 1'b1;
   logic        Go       = 1'b0;
   logic [23:0] IIC_Data = 24'h0;
   logic        End;
   logic        Ack;
   logic        IIC_Sclk;
   wire         IIC_Sda;

   logic       slave_low    = 1'b0;
   logic [2:0] slave_ack_en = 3'b111;

   assign IIC_Sda = slave_low ? 1'b0 : 1'bz;
   pullup (IIC_Sda);

   always #5 Clk_In = ~Clk_In;

   iic_write_engine #(
      .CLK_FREQ(400),
      .I2C_FREQ(20)
   ) dut (
      .Clk_In   (Clk_In),
      .Reset    (Reset),
      .IIC_Data (IIC_Data),
      .Go       (Go),
      .End      (End),
      .Ack      (Ack),
      .IIC_Sclk (IIC_Sclk),
      .IIC_Sda  (IIC_Sda)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Bus monitor and slave: START/STOP detection, bit capture on SCL rise, ACK drive on SCL fall.
   int          start_cnt   = 0;
   int          frame_stops = 0;
   int          rise_cnt    = 0;
   logic [27:0] bits        = '0;
   logic        prev_scl    = 1'b1;
   logic        prev_sda    = 1'b1;

   always @(IIC_Sclk or IIC_Sda) begin
      if (prev_scl === 1'b1 && IIC_Sclk === 1'b1 && prev_sda === 1'b1 && IIC_Sda === 1'b0) begin
         start_cnt   = start_cnt + 1;
         frame_stops = 0;
         rise_cnt    = 0;
         bits        = '0;
         slave_low   = 1'b0;
      end else if (prev_scl === 1'b1 && IIC_Sclk === 1'b1 && prev_sda === 1'b0 && IIC_Sda === 1'b1) begin
         frame_stops = frame_stops + 1;
      end
      if (prev_scl === 1'b0 && IIC_Sclk === 1'b1) begin
         if (rise_cnt < 28) bits[rise_cnt] = IIC_Sda;
         rise_cnt = rise_cnt + 1;
      end
      if (prev_scl === 1'b1 && IIC_Sclk === 1'b0) begin
         if (rise_cnt == 8)       slave_low = slave_ack_en[0];
         else if (rise_cnt == 17) slave_low = slave_ack_en[1];
         else if (rise_cnt == 26) slave_low = slave_ack_en[2];
         else                     slave_low = 1'b0;
      end
      prev_scl = IIC_Sclk;
      prev_sda = IIC_Sda;
   end

   function automatic logic [23:0] decode_data(input logic [27:0] b);
      logic [23:0] d;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         d[23-i] = b[i];
         d[15-i] = b[9+i];
         d[7-i]  = b[18+i];
      end
      return d;
   endfunction

   function automatic logic [2:0] decode_acks(input logic [27:0] b);
      return {b[26], b[17], b[8]};
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time exhausted, required completion");
      $fatal(1, "watchdog");
   end

   // Start a frame and wait (bounded) for End; optional mid-frame actions keyed on SCL rise count.
   task automatic go_and_wait(input logic [23:0] data, input int drop_rise, input int chg_rise,
                              input int rst_rise, output int cycles, output int first_low);
      int s0;
      s0        = start_cnt;
      cycles    = -1;
      first_low = -1;
      @(negedge Clk_In);
      IIC_Data = data;
      Go       = 1'b1;
      @(posedge Clk_In);
      for (int n = 1; n <= 1000; n++) begin
         @(posedge Clk_In);
         #1;
         if (first_low < 0 && IIC_Sda === 1'b0) first_low = n;
         if (start_cnt > s0) begin
            if (drop_rise >= 0 && rise_cnt >= drop_rise) Go = 1'b0;
            if (chg_rise >= 0 && rise_cnt >= chg_rise) IIC_Data = 24'h400000;
            if (rst_rise >= 0 && rise_cnt >= rst_rise) begin
               Reset  = 1'b1;
               cycles = -2;
               return;
            end
         end
         if (End === 1'b1) begin
            cycles = n;
            break;
         end
      end
      $display("frame data=%h cycles=%0d first_sda_low=%0d End=%b Ack=%b wire=%h",
               data, cycles, first_low, End, Ack, decode_data(bits));
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge Clk_In);
      #1;
      n_cmp++; if (IIC_Sclk !== 1'b1) begin n_bad++; $display("FAIL reset_scl: got %b want 1", IIC_Sclk); end
      n_cmp++; if (IIC_Sda !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want released(1)", IIC_Sda); end
      n_cmp++; if (End !== 1'b0) begin n_bad++; $display("FAIL reset_end: got %b want 0", End); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", Ack); end
      @(negedge Clk_In);
      Reset = 1'b0;
      repeat (3) @(negedge Clk_In);
      $display("reset: Sclk=%b Sda=%b End=%b Ack=%b", IIC_Sclk, IIC_Sda, End, Ack);
   endtask

   task automatic test_basic_ack();
      int cyc, fl, s0;
      slave_ack_en = 3'b111;
      s0 = start_cnt;
      go_and_wait(24'h340CFF, -1, -1, -1, cyc, fl);
      n_cmp++; if (cyc !== 566) begin n_bad++; $display("FAIL basic_latency: got %0d want 566", cyc); end
      n_cmp++; if (fl !== 5) begin n_bad++; $display("FAIL basic_first_sda_fall: got %0d want 5", fl); end
      n_cmp++; if (decode_data(bits) !== 24'h340CFF) begin n_bad++; $display("FAIL basic_data: got %h want 340cff", decode_data(bits)); end
      n_cmp++; if (decode_acks(bits) !== 3'b000) begin n_bad++; $display("FAIL basic_ack_bits: got %b want 000", decode_acks(bits)); end
      n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL basic_start: got %0d want 1", start_cnt - s0); end
      n_cmp++; if (frame_stops !== 1) begin n_bad++; $display("FAIL basic_stop: got %0d want 1", frame_stops); end
      n_cmp++; if (rise_cnt !== 28) begin n_bad++; $display("FAIL basic_scl_rises: got %0d want 28", rise_cnt); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL basic_ack: got %b want 0", Ack); end
      @(negedge Clk_In);
      Go = 1'b0;
      @(posedge Clk_In);
      #1;
      n_cmp++; if (End !== 1'b0) begin n_bad++; $display("FAIL basic_end_release: got %b want 0", End); end
   endtask

   task automatic test_nack_addr();
      int cyc, fl;
      slave_ack_en = 3'b110;
      go_and_wait(24'h340CFF, -1, -1, -1, cyc, fl);
      n_cmp++; if (cyc !== 566) begin n_bad++; $display("FAIL nack_latency: got %0d want 566", cyc); end
      n_cmp++; if (rise_cnt !== 28) begin n_bad++; $display("FAIL nack_scl_rises: got %0d want 28", rise_cnt); end
      n_cmp++; if (frame_stops !== 1) begin n_bad++; $display("FAIL nack_stop: got %0d want 1", frame_stops); end
      n_cmp++; if (decode_acks(bits) !== 3'b001) begin n_bad++; $display("FAIL nack_ack_bits: got %b want 001", decode_acks(bits)); end
      n_cmp++; if (decode_data(bits) !== 24'h340CFF) begin n_bad++; $display("FAIL nack_data: got %h want 340cff", decode_data(bits)); end
      n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL nack_ack: got %b want 1", Ack); end
      @(negedge Clk_In);
      Go = 1'b0;
      slave_ack_en = 3'b111;
      repeat (2) @(negedge Clk_In);
   endtask

   task automatic test_go_held();
      int cyc, fl, s0, end_low;
      slave_ack_en = 3'b111;
      go_and_wait(24'h340CFF, -1, -1, -1, cyc, fl);
      s0      = start_cnt;
      end_low = 0;
      repeat (20) begin
         @(posedge Clk_In);
         #1;
         if (End !== 1'b1) end_low++;
      end
      n_cmp++; if (end_low !== 0) begin n_bad++; $display("FAIL held_end_stays: got %0d low cycles want 0", end_low); end
      n_cmp++; if (start_cnt !== s0) begin n_bad++; $display("FAIL held_no_restart: got %0d starts want 0", start_cnt - s0); end
      n_cmp++; if (IIC_Sclk !== 1'b1) begin n_bad++; $display("FAIL held_scl_idle: got %b want 1", IIC_Sclk); end
      @(negedge Clk_In);
      Go = 1'b0;
      @(posedge Clk_In);
      #1;
      n_cmp++; if (End !== 1'b0) begin n_bad++; $display("FAIL held_end_fall: got %b want 0", End); end
      go_and_wait(24'h340CFF, -1, -1, -1, cyc, fl);
      n_cmp++; if (cyc !== 566) begin n_bad++; $display("FAIL held_refire_latency: got %0d want 566", cyc); end
      n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL held_refire_start: got %0d want 1", start_cnt - s0); end
      @(negedge Clk_In);
      Go = 1'b0;
      repeat (2) @(negedge Clk_In);
   endtask

   task automatic test_go_drop_pulse();
      int cyc, fl;
      slave_ack_en = 3'b011;
      go_and_wait(24'h340CFF, 11, -1, -1, cyc, fl);
      n_cmp++; if (cyc !== 566) begin n_bad++; $display("FAIL pulse_latency: got %0d want 566", cyc); end
      n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL pulse_ack_at_end: got %b want 1", Ack); end
      n_cmp++; if (frame_stops !== 1) begin n_bad++; $display("FAIL pulse_stop: got %0d want 1", frame_stops); end
      @(posedge Clk_In);
      #1;
      n_cmp++; if (End !== 1'b0) begin n_bad++; $display("FAIL pulse_end_width: got %b want 0", End); end
      n_cmp++; if (Ack !== 1'b1) begin n_bad++; $display("FAIL pulse_ack_hold: got %b want 1", Ack); end
      slave_ack_en = 3'b111;
      repeat (2) @(negedge Clk_In);
   endtask

   task automatic test_data_change();
      int cyc, fl;
      slave_ack_en = 3'b111;
      go_and_wait(24'h340CFF, 2, 4, -1, cyc, fl);
      n_cmp++; if (decode_data(bits) !== 24'h340CFF) begin n_bad++; $display("FAIL latch_data: got %h want 340cff", decode_data(bits)); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL latch_ack: got %b want 0", Ack); end
      n_cmp++; if (cyc !== 566) begin n_bad++; $display("FAIL latch_latency: got %0d want 566", cyc); end
      repeat (2) @(negedge Clk_In);
   endtask

   task automatic test_reset_mid();
      int cyc, fl, idle_bad;
      slave_ack_en = 3'b111;
      go_and_wait(24'h340CFF, -1, -1, 13, cyc, fl);
      n_cmp++; if (cyc !== -2) begin n_bad++; $display("FAIL rst_reached_slot12: got %0d want -2", cyc); end
      @(posedge Clk_In);
      #1;
      n_cmp++; if (IIC_Sclk !== 1'b1) begin n_bad++; $display("FAIL rst_mid_scl: got %b want 1", IIC_Sclk); end
      n_cmp++; if (IIC_Sda !== 1'b1) begin n_bad++; $display("FAIL rst_mid_sda: got %b want released(1)", IIC_Sda); end
      n_cmp++; if (End !== 1'b0) begin n_bad++; $display("FAIL rst_mid_end: got %b want 0", End); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 0", Ack); end
      $display("reset mid-frame: Sclk=%b Sda=%b End=%b Ack=%b", IIC_Sclk, IIC_Sda, End, Ack);
      @(negedge Clk_In);
      Reset = 1'b0;
      Go    = 1'b0;
      idle_bad = 0;
      repeat (20) begin
         @(posedge Clk_In);
         #1;
         if (IIC_Sclk !== 1'b1 || IIC_Sda !== 1'b1) idle_bad++;
      end
      n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL rst_idle_bus: got %0d active cycles want 0", idle_bad); end
      go_and_wait(24'h340CFF, -1, -1, -1, cyc, fl);
      n_cmp++; if (cyc !== 566) begin n_bad++; $display("FAIL rst_after_latency: got %0d want 566", cyc); end
      n_cmp++; if (decode_data(bits) !== 24'h340CFF) begin n_bad++; $display("FAIL rst_after_data: got %h want 340cff", decode_data(bits)); end
      n_cmp++; if (rise_cnt !== 28) begin n_bad++; $display("FAIL rst_after_rises: got %0d want 28", rise_cnt); end
      n_cmp++; if (Ack !== 1'b0) begin n_bad++; $display("FAIL rst_after_ack: got %b want 0", Ack); end
      @(negedge Clk_In);
      Go = 1'b0;
      repeat (2) @(negedge Clk_In);
   endtask

   initial begin
      test_reset();
      test_basic_ack();
      test_nack_addr();
      test_go_held();
      test_go_drop_pulse();
      test_data_change();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
